seg7_activity_counter: RTL and testbench
========================================

// Module: seg7_activity_counter
// PURPOSE
//  Parametrised board activity counter for the DE2-115 top level, driving the HEX and LED banks.
//  Prescaled CNT_W-bit counter: up/down/hold/step modes, sync clear and load.
//  Shows count nibbles on NUM_DIGITS 7-seg digits and a top-bit slice on LED_W LEDs.
//  Display outputs are registered.
// PARAMETERS
//  CNT_W       32  counter width (>=8)
//  NUM_DIGITS  8   number of 7-seg digits driven (1..8)
//  DISP_SHIFT  0   count bit index mapped to digit 0 LSB
//  LED_W       18  LED outputs; show count[CNT_W-1 -: LED_W] (LED_W<=CNT_W)
//  PRESCALE    1   iCLK cycles per count tick (>=1; 1 = every cycle)
// PORTS
//  iCLK        in   1             system clock
//  iRST        in   1             async reset, active-high
//  iCLR        in   1             sync clear of counter and prescaler
//  iLOAD       in   1             sync load of iLOAD_VAL into counter
//  iLOAD_VAL   in   CNT_W         load value
//  iMODE       in   2             00 up, 01 down, 10 hold, 11 step
//  iSTEP       in   1             async step request (key); rising edge counts in step mode
//  oCOUNT      out  CNT_W         current count
//  oTICK       out  1             1-cycle pulse on each prescaler tick
//  oHEX        out  7*NUM_DIGITS  active-low segments gfedcba; digit i at [7i+6:7i]
//  oLED        out  LED_W         count top bits, registered
// BEHAVIOUR
//  Reset: oCOUNT=0, prescaler=0, oTICK=0, oLED=0, step sync regs=0, every oHEX digit=7'h40 ("0").
//  Prescaler: 0..PRESCALE-1 wrap; tick when it reaches PRESCALE-1; PRESCALE=1 -> tick every cycle.
//  Priority per cycle: iCLR > iLOAD > mode action; iCLR zeroes counter+prescaler, oTICK=0 that cycle.
//  iLOAD: counter<=iLOAD_VAL next cycle; prescaler keeps running.
//  Up/down: +/-1 on tick, modulo 2^CNT_W (max->0, 0->max), no flag.
//  Hold: counter frozen; prescaler and oTICK still run.
//  Step: iSTEP 2-FF synchronised, rising-edge detected; +1 per edge, prescaler ignored.
//   Edge detector runs in all modes; edges outside step mode are dropped (not queued).
//  Mode change takes effect same cycle; no state reset.
//  Display: digit i = count bits [DISP_SHIFT+4i+3 : DISP_SHIFT+4i]; bits >= CNT_W read 0.
//   Hex glyphs 0-F (A,b,C,d,E,F); oHEX/oLED registered from the count one cycle later.
//   Total latency: count-changing event -> oHEX = 2 cycles.
//  Async iRST at any time returns all state to reset values immediately.
// CONFIGURATION
//  SEG7_LEAD_ZERO_BLANK_EN defined: digits above the highest nonzero digit blank (7'h7F).
//   Digit 0 always shown; count 0 -> "0" on digit 0 only.
//  Not defined: all NUM_DIGITS digits always shown, including leading zeros.
// TESTING
//  T1 reset: iRST pulse mid-count -> oCOUNT=0, oHEX all 7'h40, oLED=0 same cycle; stays until release.
//  T2 prescale: PRESCALE=4, mode up, 20 cycles -> oTICK every 4th cycle, oCOUNT=5; digit0=7'h12.
//  T3 wrap: CNT_W=8; load 8'hFF in up mode -> tick gives 0; load 0 in down mode -> tick gives 8'hFF.
//  T4 priority: iCLR, iLOAD=1, load 8'hA5 on a tick cycle -> oCOUNT=0, prescaler 0.
//   Then iLOAD alone -> oCOUNT=8'hA5; digit1=7'h08 ("A"), digit0=7'h12 ("5") two cycles later.
//  T5 step: mode 11, 3 clean iSTEP pulses -> +3 (lag 3 cycles after each edge); held high -> +1.
//   Pulse in hold mode -> no change, no later catch-up.
//  T6 macro: count 32'h0000_0012, NUM_DIGITS=8.
//   With SEG7_LEAD_ZERO_BLANK_EN: digits 7..2 = 7'h7F.
//   Without it: digits 7..2 = 7'h40.

Source files
------------

// File: rtl/seg7_activity_counter.sv
// Prescaled up/down/hold/step activity counter with registered hex and LED display outputs.
// Optional build macro SEG7_LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
`timescale 1ns/1ps

module seg7_activity_counter #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DISP_SHIFT = 0,
    parameter int unsigned LED_W      = 18,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iCLR,
    input  logic                    iLOAD,
    input  logic [CNT_W-1:0]        iLOAD_VAL,
    input  logic [1:0]              iMODE,
    input  logic                    iSTEP,
    output logic [CNT_W-1:0]        oCOUNT,
    output logic                    oTICK,
    output logic [7*NUM_DIGITS-1:0] oHEX,
    output logic [LED_W-1:0]        oLED
);

    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_HOLD = 2'b10,
        MODE_STEP = 2'b11
    } mode_e;

    mode_e mode;
    assign mode = mode_e'(iMODE);

    logic [CNT_W-1:0]        count_q, count_d;
    logic [PS_W-1:0]         presc_q, presc_d;
    logic                    tick_q, tick_d;
    logic [2:0]              step_sync_q, step_sync_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [LED_W-1:0]        led_q, led_d;

    logic             tick;
    logic             step_rise;
    logic [DIG_W-1:0] disp_bits;
    logic [3:0]       nib;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    logic             upper_nz;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Counter, prescaler and step synchroniser
    always_comb begin
        tick        = (presc_q == PS_LAST);
        step_rise   = step_sync_q[1] & ~step_sync_q[2];
        step_sync_d = {step_sync_q[1:0], iSTEP};
        presc_d     = tick ? '0 : presc_q + PS_ONE;
        tick_d      = tick;
        count_d     = count_q;
        if (iCLR) begin
            count_d = '0;
            presc_d = '0;
            tick_d  = 1'b0;
        end else if (iLOAD) begin
            count_d = iLOAD_VAL;
        end else begin
            case (mode)
                MODE_UP:   if (tick) count_d = count_q + CNT_ONE;
                MODE_DOWN: if (tick) count_d = count_q - CNT_ONE;
                MODE_HOLD: count_d = count_q;
                MODE_STEP: if (step_rise) count_d = count_q + CNT_ONE;
                default:   count_d = count_q;
            endcase
        end
    end

    // Zero-extend above the counter so digits past CNT_W decode as 0
    always_comb begin
        disp_bits = DIG_W'({{DIG_W{1'b0}}, count_q} >> DISP_SHIFT);
        led_d     = count_q[CNT_W-1 -: LED_W];
        hex_d     = '0;
        nib       = '0;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        upper_nz  = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            nib = disp_bits[4*(NUM_DIGITS-1-k) +: 4];
`ifdef SEG7_LEAD_ZERO_BLANK_EN
            upper_nz = upper_nz | (nib != 4'h0);
            if ((k != NUM_DIGITS - 1) && !upper_nz)
                hex_d[7*(NUM_DIGITS-1-k) +: 7] = 7'h7F;
            else
                hex_d[7*(NUM_DIGITS-1-k) +: 7] = seg7(nib);
`else
            hex_d[7*(NUM_DIGITS-1-k) +: 7] = seg7(nib);
`endif
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count_q     <= '0;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            step_sync_q <= '0;
            hex_q       <= {NUM_DIGITS{7'h40}};
            led_q       <= '0;
        end else begin
            count_q     <= count_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            step_sync_q <= step_sync_d;
            hex_q       <= hex_d;
            led_q       <= led_d;
        end
    end

    assign oCOUNT = count_q;
    assign oTICK  = tick_q;
    assign oHEX   = hex_q;
    assign oLED   = led_q;

endmodule

// File: tb/tb_seg7_activity_counter.sv
// Scoreboard bench for seg7_activity_counter: directed scenarios then random traffic vs a behavioural model.
`timescale 1ns/1ps

module tb_seg7_activity_counter;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DISP_SHIFT = 0;
    localparam int unsigned LED_W      = 4;
    localparam int unsigned PRESCALE   = 4;
    localparam int          MOD        = 1 << CNT_W;

    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [CNT_W-1:0]        cnt;
        logic                    tick;
        logic [7*NUM_DIGITS-1:0] hex;
        logic [LED_W-1:0]        led;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    iRST = 1'b0;
    logic                    iCLR = 1'b0;
    logic                    iLOAD = 1'b0;
    logic [CNT_W-1:0]        iLOAD_VAL = '0;
    logic [1:0]              iMODE = 2'b00;
    logic                    iSTEP = 1'b0;
    logic [CNT_W-1:0]        oCOUNT;
    logic                    oTICK;
    logic [7*NUM_DIGITS-1:0] oHEX;
    logic [LED_W-1:0]        oLED;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    int   m_cnt = 0;
    int   m_pcnt = 0;
    bit   hist[$];

    seg7_activity_counter #(
        .CNT_W(CNT_W), .NUM_DIGITS(NUM_DIGITS), .DISP_SHIFT(DISP_SHIFT),
        .LED_W(LED_W), .PRESCALE(PRESCALE)
    ) dut (
        .iCLK(clk), .iRST(iRST), .iCLR(iCLR), .iLOAD(iLOAD), .iLOAD_VAL(iLOAD_VAL),
        .iMODE(iMODE), .iSTEP(iSTEP), .oCOUNT(oCOUNT), .oTICK(oTICK), .oHEX(oHEX), .oLED(oLED)
    );

    always #5 clk = ~clk;

    function automatic logic [7*NUM_DIGITS-1:0] disp(input int v);
        logic [7*NUM_DIGITS-1:0] h;
        int sh;
        h = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sh = v >> (DISP_SHIFT + 4 * i);
            h[7*i +: 7] = GLYPH[sh % 16];
`ifdef SEG7_LEAD_ZERO_BLANK_EN
            if (i > 0 && sh == 0) h[7*i +: 7] = 7'h7F;
`endif
        end
        return h;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.cnt  = '0;
        e.tick = 1'b0;
        e.hex  = {NUM_DIGITS{7'h40}};
        e.led  = '0;
        return e;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_pcnt = 0;
        hist   = '{0, 0, 0, 0};
    endtask

    // Applies one cycle of inputs (called just after a falling edge) and queues what the next sample must show
    task automatic drive(input bit rst, input bit clr, input bit load, input logic [CNT_W-1:0] val,
                         input logic [1:0] mode, input bit stp);
        exp_t e;
        int   old;
        bit   tk;
        bit   rose;
        int   np;
        iCLR = clr; iLOAD = load; iLOAD_VAL = val; iMODE = mode; iSTEP = stp;
        if (rst) begin
            if (!iRST) begin
                mon_en = 1'b1;
                model_reset();
                exp_q.push_back(reset_exp());
                iRST = 1'b1;
            end
            exp_q.push_back(reset_exp());
            return;
        end
        iRST = 1'b0;
        old  = m_cnt;
        tk   = (m_pcnt == PRESCALE - 1);
        hist.push_front(stp);
        rose = hist[2] && !hist[3];
        void'(hist.pop_back());
        np = (m_pcnt + 1) % PRESCALE;
        if (clr) begin
            m_cnt = 0;
            np    = 0;
            tk    = 1'b0;
        end else if (load) begin
            m_cnt = int'(val);
        end else begin
            case (mode)
                2'b00: if (tk) m_cnt = (m_cnt + 1) % MOD;
                2'b01: if (tk) m_cnt = (m_cnt + MOD - 1) % MOD;
                2'b10: ;
                default: if (rose) m_cnt = (m_cnt + 1) % MOD;
            endcase
        end
        m_pcnt = np;
        e.cnt  = CNT_W'(m_cnt);
        e.tick = tk;
        e.hex  = disp(old);
        e.led  = LED_W'(old >> (CNT_W - LED_W));
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit clr, input bit load, input logic [CNT_W-1:0] val,
                       input logic [1:0] mode, input bit stp);
        @(negedge clk);
        drive(1'b0, clr, load, val, mode, stp);
    endtask

    task automatic rst_cyc();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0, 2'b00, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or posedge iRST);
            #1;
            if (mon_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow: no expected entry at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (oCOUNT !== e.cnt) begin
                        n_fail++;
                        $display("FAIL count t=%0t got=%h exp=%h", $time, oCOUNT, e.cnt);
                    end
                    n_checks++;
                    if (oTICK !== e.tick) begin
                        n_fail++;
                        $display("FAIL tick t=%0t got=%b exp=%b", $time, oTICK, e.tick);
                    end
                    n_checks++;
                    if (oHEX !== e.hex) begin
                        n_fail++;
                        $display("FAIL hex t=%0t got=%h exp=%h", $time, oHEX, e.hex);
                    end
                    n_checks++;
                    if (oLED !== e.led) begin
                        n_fail++;
                        $display("FAIL led t=%0t got=%h exp=%h", $time, oLED, e.led);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit               r_rst;
        bit               r_clr;
        bit               r_load;
        logic [CNT_W-1:0] r_val;
        logic [1:0]       r_mode;
        bit               r_stp;
        int               guard;

        rst_cyc();
        rst_cyc();

        // Free-running up count through the prescaler
        repeat (20) cyc(0, 0, '0, 2'b00, 0);

        // Wrap in both directions
        cyc(0, 1, 8'hFF, 2'b00, 0);
        repeat (5) cyc(0, 0, '0, 2'b00, 0);
        cyc(0, 1, 8'h00, 2'b01, 0);
        repeat (5) cyc(0, 0, '0, 2'b01, 0);

        // Clear beats load on a tick cycle, then load alone
        guard = 0;
        while (m_pcnt != PRESCALE - 1 && guard < PRESCALE) begin
            cyc(0, 0, '0, 2'b00, 0);
            guard++;
        end
        cyc(1, 1, 8'hA5, 2'b00, 0);
        cyc(0, 1, 8'hA5, 2'b10, 0);
        repeat (3) cyc(0, 0, '0, 2'b10, 0);

        // Step mode: clean pulses, long hold, then a pulse in hold mode that must be dropped
        repeat (3) begin
            repeat (2) cyc(0, 0, '0, 2'b11, 1);
            repeat (3) cyc(0, 0, '0, 2'b11, 0);
        end
        repeat (10) cyc(0, 0, '0, 2'b11, 1);
        repeat (4) cyc(0, 0, '0, 2'b11, 0);
        repeat (2) cyc(0, 0, '0, 2'b10, 1);
        repeat (4) cyc(0, 0, '0, 2'b10, 0);
        repeat (5) cyc(0, 0, '0, 2'b11, 0);

        // Display patterns including leading zeros and digits beyond the counter width
        cyc(0, 1, 8'h12, 2'b10, 0);
        repeat (3) cyc(0, 0, '0, 2'b10, 0);
        cyc(0, 1, 8'h05, 2'b10, 0);
        repeat (3) cyc(0, 0, '0, 2'b10, 0);
        cyc(0, 1, 8'h00, 2'b10, 0);
        repeat (3) cyc(0, 0, '0, 2'b10, 0);
        cyc(0, 1, 8'hC3, 2'b10, 0);
        repeat (3) cyc(0, 0, '0, 2'b10, 0);

        // Randomised traffic
        r_rst  = 0;
        r_mode = 2'b00;
        r_stp  = 0;
        repeat (3000) begin
            if (r_rst) r_rst = ($urandom_range(0, 2) != 0);
            else       r_rst = ($urandom_range(0, 199) == 0);
            r_clr  = ($urandom_range(0, 23) == 0);
            r_load = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: r_val = 8'hFF;
                1: r_val = 8'h00;
                default: r_val = CNT_W'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) r_mode = 2'($urandom);
            if ($urandom_range(0, 2) == 0) r_stp = ~r_stp;
            @(negedge clk);
            drive(r_rst, r_clr, r_load, r_val, r_mode, r_stp);
        end

        // Reset arriving mid-count, held several cycles
        cyc(0, 1, 8'h7E, 2'b00, 0);
        repeat (6) cyc(0, 0, '0, 2'b00, 0);
        repeat (3) rst_cyc();
        repeat (6) cyc(0, 0, '0, 2'b00, 0);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got=%0d pending exp=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
